// File: rtl/intc_pkg.sv
// Shared types and constants for the eight-input interrupt controller.
package intc_pkg;

  // Handshake with the CPU: idle, request outstanding, waiting for inta to drop.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAITLO = 2'd2
  } state_t;

  // Register port addresses.
  localparam logic [1:0] ADDR_IMR  = 2'd0;
  localparam logic [1:0] ADDR_BASE = 2'd1;
  localparam logic [1:0] ADDR_IRR  = 2'd2;
  localparam logic [1:0] ADDR_ISR  = 2'd3;

  // Every source starts out masked.
  localparam logic [7:0] IMR_RST = 8'hFF;

  // One-hot mask selecting a single source.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/intc_prio.sv
// Eight-bit fixed-priority encoder; bit 0 has the highest priority.
module intc_prio (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from the lowest priority upward so the lowest set index is the one left in idx.
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx = i[2:0];
      end
    end
  end

endmodule

// File: rtl/intc.sv
// Programmable interrupt controller: edge-latched requests, mask, fixed priority with
// nesting against in-service sources, and a frozen vector held until the CPU acknowledges.
module intc
  import intc_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] irq,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  input  logic       eoi,
  output logic       intr,
  output logic [7:0] vector,
  input  logic       inta
);

  logic [7:0] r_irq_q;
  logic [7:0] r_irr;
  logic [7:0] r_isr;
  logic [7:0] r_imr;
  logic [4:0] r_base;
  logic [7:0] r_rdata;
  state_t     r_state;
  logic       r_intr;
  logic [7:0] r_vector;
  logic [2:0] r_idx;

  logic [7:0] w_edge;
  logic [7:0] w_pend;
  logic       w_pend_valid;
  logic [2:0] w_pend_idx;
  logic       w_isr_valid;
  logic [2:0] w_isr_idx;
  logic       w_eligible;
  logic       w_ack;
  logic [7:0] w_ack_mask;
  logic [7:0] w_eoi_mask;
  logic [7:0] w_irr_nxt;
  logic [7:0] w_isr_nxt;
  logic [7:0] w_rdata_nxt;
  state_t     w_state_nxt;
  logic       w_intr_nxt;
  logic [7:0] w_vector_nxt;
  logic [2:0] w_idx_nxt;

  assign w_edge = irq & ~r_irq_q;
  assign w_pend = r_irr & ~r_imr;

  intc_prio u_prio_pend (
    .req   (w_pend),
    .valid (w_pend_valid),
    .idx   (w_pend_idx)
  );

  intc_prio u_prio_isr (
    .req   (r_isr),
    .valid (w_isr_valid),
    .idx   (w_isr_idx)
  );

  // Nesting: only sources strictly more urgent than the highest in-service one may interrupt.
  assign w_eligible = w_pend_valid && (!w_isr_valid || (w_pend_idx < w_isr_idx));

  // Handshake FSM next-state and registered-output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_intr_nxt   = r_intr;
    w_vector_nxt = r_vector;
    w_idx_nxt    = r_idx;
    w_ack        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_eligible) begin
          w_idx_nxt    = w_pend_idx;
          w_vector_nxt = {r_base, w_pend_idx};
          w_intr_nxt   = 1'b1;
          w_state_nxt  = REQ;
        end
      end
      REQ: begin
        // Never retracted here, even if the source gets masked while waiting.
        if (inta) begin
          w_ack       = 1'b1;
          w_intr_nxt  = 1'b0;
          w_state_nxt = WAITLO;
        end
      end
      WAITLO: begin
        // A long inta must not acknowledge a second source.
        if (!inta) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_intr_nxt  = 1'b0;
      end
    endcase
  end

  // IRR/ISR update: a fresh edge beats the acknowledge clear; eoi retires before the new set.
  always_comb begin
    w_ack_mask = w_ack ? onehot8(r_idx) : 8'h00;
    w_eoi_mask = (eoi && w_isr_valid) ? onehot8(w_isr_idx) : 8'h00;
    w_irr_nxt  = (r_irr & ~w_ack_mask) | w_edge;
    w_isr_nxt  = (r_isr & ~w_eoi_mask) | w_ack_mask;
  end

  // Read mux; registered below so reads show the pre-edge register contents.
  always_comb begin
    w_rdata_nxt = 8'h00;
    case (cfg_addr)
      ADDR_IMR:  w_rdata_nxt = r_imr;
      ADDR_BASE: w_rdata_nxt = {r_base, 3'b000};
      ADDR_IRR:  w_rdata_nxt = r_irr;
      ADDR_ISR:  w_rdata_nxt = r_isr;
      default:   w_rdata_nxt = 8'h00;
    endcase
  end

  // FSM state and CPU-facing outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= IDLE;
      r_intr   <= 1'b0;
      r_vector <= 8'h00;
      r_idx    <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_intr   <= w_intr_nxt;
      r_vector <= w_vector_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

  // Request capture and in-service tracking.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_irq_q <= 8'h00;
      r_irr   <= 8'h00;
      r_isr   <= 8'h00;
    end else begin
      r_irq_q <= irq;
      r_irr   <= w_irr_nxt;
      r_isr   <= w_isr_nxt;
    end
  end

  // Configuration registers and registered read data.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_imr   <= IMR_RST;
      r_base  <= 5'd0;
      r_rdata <= 8'h00;
    end else begin
      r_rdata <= w_rdata_nxt;
      if (cfg_we) begin
        case (cfg_addr)
          ADDR_IMR:  r_imr  <= cfg_wdata;
          ADDR_BASE: r_base <= cfg_wdata[7:3];
          default:   ;
        endcase
      end
    end
  end

  assign cfg_rdata = r_rdata;
  assign intr      = r_intr;
  assign vector    = r_vector;

endmodule

// File: tb/tb_intc.sv
// Directed self-checking bench for the interrupt controller.
module tb_intc;

  logic       clk;
  logic       clrn;
  logic [7:0] irq;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       eoi;
  logic       intr;
  logic [7:0] vector;
  logic       inta;

  int n_tests;
  int n_fail;

  intc dut (
    .clk       (clk),
    .clrn      (clrn),
    .irq       (irq),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .eoi       (eoi),
    .intr      (intr),
    .vector    (vector),
    .inta      (inta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    cyc(1);
    clrn = 1'b1;
    cyc(1);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    cyc(1);
    cfg_we    = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] addr, output logic [7:0] data);
    cfg_addr = addr;
    cyc(1);
    data = cfg_rdata;
  endtask

  task automatic ack();
    inta = 1'b1;
    cyc(1);
    inta = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    cyc(1);
    eoi = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    clrn = 1'b0; irq = 8'h00; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
    eoi = 1'b0; inta = 1'b0;
    #2;
    n_tests++;
    if (intr !== 1'b0 || vector !== 8'h00 || cfg_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: intr=%b vector=%h rdata=%h, want 0/00/00", intr, vector,
               cfg_rdata);
    end
    cyc(2);
    clrn = 1'b1;
    cyc(1);
    irq = 8'hFF;
    cyc(1);
    irq = 8'h00;
    cyc(2);
    n_tests++;
    if (intr !== 1'b0) begin
      n_fail++;
      $display("FAIL masked_no_intr: intr=%b, want 0", intr);
    end
    cfg_read(2'd2, rd);
    n_tests++;
    if (rd !== 8'hFF) begin
      n_fail++;
      $display("FAIL irr_all_set: IRR=%h, want ff", rd);
    end
    cfg_read(2'd0, rd);
    n_tests++;
    if (rd !== 8'hFF) begin
      n_fail++;
      $display("FAIL imr_reset: IMR=%h, want ff", rd);
    end
  endtask

  task automatic test_basic_ack();
    logic [7:0] rd;
    do_reset();
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd1, 8'h20);
    irq = 8'h20;
    cyc(1);
    n_tests++;
    if (intr !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: intr=%b one cycle after edge, want 0", intr);
    end
    cyc(1);
    n_tests++;
    if (intr !== 1'b1 || vector !== 8'h25) begin
      n_fail++;
      $display("FAIL basic_req: intr=%b vector=%h, want 1/25", intr, vector);
    end
    irq  = 8'h00;
    inta = 1'b1;
    cyc(1);
    n_tests++;
    if (intr !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_drop: intr=%b, want 0", intr);
    end
    cyc(2);
    n_tests++;
    if (intr !== 1'b0) begin
      n_fail++;
      $display("FAIL long_inta: intr=%b while inta held, want 0", intr);
    end
    inta = 1'b0;
    cyc(1);
    cfg_read(2'd3, rd);
    n_tests++;
    if (rd !== 8'h20) begin
      n_fail++;
      $display("FAIL isr_after_ack: ISR=%h, want 20", rd);
    end
    cfg_read(2'd2, rd);
    n_tests++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL irr_after_ack: IRR=%h, want 00", rd);
    end
    pulse_eoi();
  endtask

  task automatic test_priority();
    logic [7:0] rd;
    irq = 8'h44;
    cyc(2);
    n_tests++;
    if (intr !== 1'b1 || vector !== 8'h22) begin
      n_fail++;
      $display("FAIL prio_first: intr=%b vector=%h, want 1/22", intr, vector);
    end
    irq = 8'h00;
    ack();
    cyc(2);
    n_tests++;
    if (intr !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_blocked: intr=%b with ISR bit 2 set, want 0", intr);
    end
    cfg_read(2'd2, rd);
    n_tests++;
    if (rd !== 8'h40) begin
      n_fail++;
      $display("FAIL prio_irr_held: IRR=%h, want 40", rd);
    end
    pulse_eoi();
    cyc(1);
    n_tests++;
    if (intr !== 1'b1 || vector !== 8'h26) begin
      n_fail++;
      $display("FAIL prio_after_eoi: intr=%b vector=%h, want 1/26", intr, vector);
    end
    ack();
    pulse_eoi();
  endtask

  task automatic test_nesting();
    logic [7:0] rd;
    irq = 8'h20;
    cyc(2);
    n_tests++;
    if (intr !== 1'b1 || vector !== 8'h25) begin
      n_fail++;
      $display("FAIL nest_outer: intr=%b vector=%h, want 1/25", intr, vector);
    end
    irq = 8'h00;
    ack();
    irq = 8'h02;
    cyc(2);
    n_tests++;
    if (intr !== 1'b1 || vector !== 8'h21) begin
      n_fail++;
      $display("FAIL nest_inner: intr=%b vector=%h, want 1/21", intr, vector);
    end
    irq = 8'h00;
    ack();
    cfg_read(2'd3, rd);
    n_tests++;
    if (rd !== 8'h22) begin
      n_fail++;
      $display("FAIL nest_isr: ISR=%h, want 22", rd);
    end
    pulse_eoi();
    cfg_read(2'd3, rd);
    n_tests++;
    if (rd !== 8'h20) begin
      n_fail++;
      $display("FAIL nest_eoi: ISR=%h, want 20", rd);
    end
    pulse_eoi();
  endtask

  task automatic test_mask();
    logic [7:0] rd;
    cfg_write(2'd0, 8'h08);
    irq = 8'h08;
    cyc(2);
    n_tests++;
    if (intr !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_blocks: intr=%b, want 0", intr);
    end
    irq = 8'h00;
    cfg_read(2'd2, rd);
    n_tests++;
    if (rd !== 8'h08) begin
      n_fail++;
      $display("FAIL mask_irr: IRR=%h, want 08", rd);
    end
    cfg_write(2'd0, 8'h00);
    cfg_addr = 2'd2;
    cyc(1);
    n_tests++;
    if (intr !== 1'b1 || vector !== 8'h23 || cfg_rdata !== 8'h08) begin
      n_fail++;
      $display("FAIL unmask_req: intr=%b vector=%h rdata=%h, want 1/23/08", intr, vector,
               cfg_rdata);
    end
  endtask

  task automatic test_reset_in_req();
    logic [7:0] rd;
    clrn = 1'b0;
    #1;
    n_tests++;
    if (intr !== 1'b0 || vector !== 8'h00 || cfg_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: intr=%b vector=%h rdata=%h, want 0/00/00", intr, vector,
               cfg_rdata);
    end
    cyc(1);
    clrn = 1'b1;
    cyc(1);
    cfg_read(2'd0, rd);
    n_tests++;
    if (rd !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_imr: IMR=%h, want ff", rd);
    end
    cfg_read(2'd3, rd);
    n_tests++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_isr: ISR=%h, want 00", rd);
    end
    cfg_read(2'd2, rd);
    n_tests++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_irr: IRR=%h, want 00", rd);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic_ack();
    test_priority();
    test_nesting();
    test_mask();
    test_reset_in_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
